axi_st_csr_mc: RTL
==================

Name: axi_st_csr_mc

Overview:
Multi-channel CSR block for the AXI-ST link examples. It replaces single-channel CSR control with NUM_CH independent channel register banks, each with:
- pattern-generator controls,
- checker status with sticky error capture,
- an armable first/last data-capture window,
- a beat counter.

It exposes a single-clock Avalon-MM slave, normally driven by the JTAG-to-AVMM bridge, plus global link status, delay values and a timed soft-reset pulse.

Parameters:
- NUM_CH, 2, number of AXI-ST channels (1..8).
- CAP_W, 512, capture data width per channel; multiple of 32, max 512.
- ADDR_W, 16, Avalon byte-address width.
- RST_PULSE, 16, cycles axist_rstn_out is held low after reset or a soft-reset trigger (2..255).

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous active-low reset.
- avmm_address  in  ADDR_W  byte address; bits [1:0] ignored.
- avmm_read  in  1  read request.
- avmm_write  in  1  write request.
- avmm_writedata  in  32  write data.
- avmm_byteenable  in  4  write byte lanes.
- avmm_readdata  out  32  read data.
- avmm_readdatavalid  out  1  read data qualifier.
- avmm_waitrequest  out  1  stall.
- chkr_pass  in  2*NUM_CH  per-channel checker result; live value.
- align_error  in  NUM_CH  per-channel alignment error pulse/level.
- link_online  in  4  {fllr_rx, fllr_tx, ldr_rx, ldr_tx}.
- cap_data  in  NUM_CH*CAP_W  per-channel capture data.
- cap_valid  in  NUM_CH  per-channel capture qualifier.
- o_delay_x_value / o_delay_y_value / o_delay_z_value  out  32 each  delay registers.
- axist_rstn_out  out  1  soft reset to AXI-ST datapath, active low.
- csr_patgen_en  out  NUM_CH  per-channel pattern generator enable.
- csr_patgen_sel  out  2*NUM_CH  per-channel pattern select.
- csr_patgen_cnt  out  9*NUM_CH  per-channel pattern count.
- csr_cntuspatt_en  out  NUM_CH  per-channel continuous-pattern enable.

Behaviour:
- Reset values:
  - all outputs 0 except avmm_waitrequest=0;
  - delay registers 0;
  - all channels armed;
  - beat counters 0;
  - capture registers 0;
  - pulse counter loaded with RST_PULSE.
- Address map, global registers (RW registers honour byteenable):
  - 0x000 ID (RO): {8'hA5, NUM_CH[7:0], CAP_W/32 [7:0], 8'h01}.
  - 0x004 CTRL: bit0 soft-reset trigger, write-1, self-clearing, reads 0.
  - 0x008 LINK (RO): {28'b0, link_online}.
  - 0x00C / 0x010 / 0x014: delay x / y / z (RW).
- Address map, channel c base = 0x100 + c*0x100:
  - +0x00 CH_CTRL:
    - bit0 patgen_en, bits2:1 patgen_sel, bit3 cntuspatt_en, bits16:8 patgen_cnt;
    - bit31 arm: write-1, self-clearing, reads 0.
  - +0x04 CH_STAT:
    - bits1:0 live chkr_pass;
    - bit2 sticky align_error, W1C;
    - bit4 first_captured (RO).
  - +0x08 BEATS (RO): 32-bit saturating count of cap_valid beats since arm.
  - +0x40+4k: first-capture word k (k < CAP_W/32), bits [32k+31:32k].
  - +0x80+4k: last-capture word k.
- Unmapped or out-of-range reads, including channel index ≥ NUM_CH, return 0. Writes to RO or unmapped addresses are ignored.
- Write timing: a write is accepted in any cycle with waitrequest=0 and takes effect on the next edge. Control outputs are registered and change 1 cycle after acceptance.
- Read timing:
  - a read is accepted with waitrequest=0;
  - stage 1 registers the decode, stage 2 registers the mux;
  - readdatavalid pulses exactly 2 cycles after acceptance;
  - waitrequest is high for the 2 cycles following a read acceptance, so only one read is outstanding;
  - read and write asserted together: the write executes and the read is ignored.
- Sticky error:
  - align_error high sets bit2;
  - W1C clears it;
  - set and clear in the same cycle: set wins.
- Capture, per channel:
  - arm write clears first_captured and BEATS;
  - while first_captured=0, a cap_valid beat loads both first and last registers and sets first_captured;
  - later beats load last only;
  - BEATS increments per beat and saturates at 0xFFFF_FFFF;
  - arm write and cap_valid in the same cycle: arm wins and that beat is discarded;
  - capture registers are not cleared by arm.
- Soft reset:
  - axist_rstn_out=0 while the pulse counter is nonzero;
  - after rst_n deasserts, it stays low RST_PULSE cycles, then goes 1;
  - a CTRL bit0 write reloads the counter to RST_PULSE, including mid-pulse, which restarts the pulse;
  - channel CSRs are unaffected by a soft reset.
- rst_n asserted mid-read: the pending readdatavalid is dropped and waitrequest goes 0.

Decomposition:
- Package axi_st_csr_pkg holds:
  - register offsets, channel stride 0x100, capture window offsets 0x40 and 0x80;
  - CH_CTRL/CH_STAT bit positions;
  - the ID constant 8'hA5.
- Sub-module axi_st_csr_chan holds one channel's CH_CTRL, CH_STAT, BEATS, capture registers and read mux. The top generates NUM_CH instances plus the global registers, read pipeline and reset pulser.

Test Plan:
1. Reset release, RST_PULSE=16 → axist_rstn_out low for exactly 16 cycles then 1; read 0x000 with NUM_CH=2, CAP_W=512 returns 0xA5021001, readdatavalid 2 cycles after accept.
2. Write 0x200 = 0x0001_2B0D with all byteenables → csr_patgen_en[1]=1, patgen_sel[3:2]=2'b10, cntuspatt_en[1]=1, patgen_cnt[17:9]=9'h12B, channel 0 outputs unchanged. Repeat with byteenable=4'b0001 → only bits7:0 update.
3. Pulse align_error[0] one cycle; read 0x104 bit2=1; write 0x104=0x4 with align_error held high the same cycle → bit2 stays 1; next W1C with no error → 0.
4. Arm ch0, drive 3 beats with data 0x11.., 0x22.., 0x33.. → first word0 = 0x1111_1111, last word0 = 0x3333_3333, BEATS=3, first_captured=1. Arm coincident with a beat → BEATS=0 and the beat is not captured.
5. Back-to-back reads to 0x008 and 0x00C → waitrequest high 2 cycles after the first accept, 2 readdatavalid pulses in order with correct data. Read 0x400 with NUM_CH=2 → 0.
6. Write CTRL bit0 mid-pulse at cycle 8 of a 16-cycle pulse → low period extends to 16 cycles from the write. Force BEATS to saturate → stays at 0xFFFF_FFFF.

Source files
------------

// File: rtl/axi_st_csr_pkg.sv
// Shared constants, write payload type and helpers for the multi-channel AXI-ST CSR block.
package axi_st_csr_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned BE_W      = DATA_W / 8;
  localparam int unsigned CH_STRIDE = 32'h100;
  localparam int unsigned OFF_W     = $clog2(CH_STRIDE);

  // Global register offsets (page 0)
  localparam logic [OFF_W-1:0] REG_ID    = 8'h00;
  localparam logic [OFF_W-1:0] REG_CTRL  = 8'h04;
  localparam logic [OFF_W-1:0] REG_LINK  = 8'h08;
  localparam logic [OFF_W-1:0] REG_DLY_X = 8'h0C;
  localparam logic [OFF_W-1:0] REG_DLY_Y = 8'h10;
  localparam logic [OFF_W-1:0] REG_DLY_Z = 8'h14;

  // Per-channel offsets within a channel page
  localparam logic [OFF_W-1:0] CH_CTRL       = 8'h00;
  localparam logic [OFF_W-1:0] CH_STAT       = 8'h04;
  localparam logic [OFF_W-1:0] CH_BEATS      = 8'h08;
  localparam logic [OFF_W-1:0] CAP_FIRST_OFF = 8'h40;
  localparam logic [OFF_W-1:0] CAP_LAST_OFF  = 8'h80;

  localparam int unsigned GCTRL_SRST_BIT = 0;
  localparam int unsigned CTRL_EN_BIT    = 0;
  localparam int unsigned CTRL_SEL_LSB   = 1;
  localparam int unsigned CTRL_CNTUS_BIT = 3;
  localparam int unsigned CTRL_CNT_LSB   = 8;
  localparam int unsigned CTRL_ARM_BIT   = 31;
  localparam int unsigned STAT_PASS_LSB  = 0;
  localparam int unsigned STAT_ALIGN_BIT = 2;
  localparam int unsigned STAT_FIRST_BIT = 4;

  localparam logic [7:0] ID_TAG = 8'hA5;
  localparam logic [7:0] ID_VER = 8'h01;

  typedef struct packed {
    logic [OFF_W-1:0]  off;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } csr_wr_t;

  function automatic logic [DATA_W-1:0] be_merge(input logic [DATA_W-1:0] cur,
                                                 input logic [DATA_W-1:0] nxt,
                                                 input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] r;
    r = cur;
    for (int i = 0; i < int'(BE_W); i++) begin
      if (be[i]) r[8*i +: 8] = nxt[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_st_csr_chan.sv
// One channel bank: pattern-gen controls, sticky status, capture window, beat counter, read mux.
module axi_st_csr_chan
  import axi_st_csr_pkg::*;
#(
  parameter int unsigned CAP_W = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  csr_wr_t           wr,
  input  logic [OFF_W-1:0]  rd_off,
  output logic [DATA_W-1:0] rd_data_c,
  input  logic [1:0]        chkr_pass,
  input  logic              align_error,
  input  logic [CAP_W-1:0]  cap_data,
  input  logic              cap_valid,
  output logic              patgen_en,
  output logic [1:0]        patgen_sel,
  output logic [8:0]        patgen_cnt,
  output logic              cntuspatt_en
);

  localparam int unsigned NW    = CAP_W / DATA_W;
  localparam int unsigned IDX_W = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [31:0] BEATS_MAX = '1;

  logic [NW-1:0][DATA_W-1:0] first_q;
  logic [NW-1:0][DATA_W-1:0] last_q;
  logic              first_cap;
  logic              align_sticky;
  logic [31:0]       beats;
  logic              ctrl_wr;
  logic              arm;
  logic              stat_clr;
  logic [IDX_W-1:0]  win_idx;
  logic              win_ok;
  logic              unused_c;

  assign ctrl_wr  = wr_en && (wr.off == CH_CTRL);
  assign arm      = ctrl_wr && wr.be[3] && wr.data[CTRL_ARM_BIT];
  assign stat_clr = wr_en && (wr.off == CH_STAT) && wr.be[0] && wr.data[STAT_ALIGN_BIT];
  assign win_idx  = rd_off[2 +: IDX_W];
  assign win_ok   = {1'b0, rd_off[5:2]} < 5'(NW);
  assign unused_c = ^{wr.data[30:17], wr.data[7:4]};

  // Control fields, byte-lane gated
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      patgen_en    <= 1'b0;
      patgen_sel   <= '0;
      patgen_cnt   <= '0;
      cntuspatt_en <= 1'b0;
    end else if (ctrl_wr) begin
      if (wr.be[0]) begin
        patgen_en    <= wr.data[CTRL_EN_BIT];
        patgen_sel   <= wr.data[CTRL_SEL_LSB +: 2];
        cntuspatt_en <= wr.data[CTRL_CNTUS_BIT];
      end
      if (wr.be[1]) patgen_cnt[7:0] <= wr.data[CTRL_CNT_LSB +: 8];
      if (wr.be[2]) patgen_cnt[8]   <= wr.data[CTRL_CNT_LSB + 8];
    end
  end

  // Sticky alignment error: a new error beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          align_sticky <= 1'b0;
    else if (align_error) align_sticky <= 1'b1;
    else if (stat_clr)   align_sticky <= 1'b0;
  end

  // Capture window; arm drops any beat arriving in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q   <= '0;
      last_q    <= '0;
      first_cap <= 1'b0;
      beats     <= '0;
    end else if (arm) begin
      first_cap <= 1'b0;
      beats     <= '0;
    end else if (cap_valid) begin
      last_q <= cap_data;
      if (!first_cap) begin
        first_q   <= cap_data;
        first_cap <= 1'b1;
      end
      if (beats != BEATS_MAX) beats <= beats + 32'd1;
    end
  end

  always_comb begin
    rd_data_c = '0;
    if (rd_off == CH_CTRL) begin
      rd_data_c[CTRL_EN_BIT]          = patgen_en;
      rd_data_c[CTRL_SEL_LSB +: 2]    = patgen_sel;
      rd_data_c[CTRL_CNTUS_BIT]       = cntuspatt_en;
      rd_data_c[CTRL_CNT_LSB +: 9]    = patgen_cnt;
    end else if (rd_off == CH_STAT) begin
      rd_data_c[STAT_PASS_LSB +: 2]   = chkr_pass;
      rd_data_c[STAT_ALIGN_BIT]       = align_sticky;
      rd_data_c[STAT_FIRST_BIT]       = first_cap;
    end else if (rd_off == CH_BEATS) begin
      rd_data_c = beats;
    end else if (win_ok && (rd_off[7:6] == CAP_FIRST_OFF[7:6])) begin
      rd_data_c = first_q[win_idx];
    end else if (win_ok && (rd_off[7:6] == CAP_LAST_OFF[7:6])) begin
      rd_data_c = last_q[win_idx];
    end
  end

endmodule

// File: rtl/axi_st_csr_mc.sv
// Multi-channel AXI-ST CSR block: Avalon-MM slave, global registers, soft-reset pulser, channel banks.
module axi_st_csr_mc
  import axi_st_csr_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned CAP_W     = 512,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned RST_PULSE = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_W-1:0]       avmm_address,
  input  logic                    avmm_read,
  input  logic                    avmm_write,
  input  logic [31:0]             avmm_writedata,
  input  logic [3:0]              avmm_byteenable,
  output logic [31:0]             avmm_readdata,
  output logic                    avmm_readdatavalid,
  output logic                    avmm_waitrequest,
  input  logic [2*NUM_CH-1:0]     chkr_pass,
  input  logic [NUM_CH-1:0]       align_error,
  input  logic [3:0]              link_online,
  input  logic [NUM_CH*CAP_W-1:0] cap_data,
  input  logic [NUM_CH-1:0]       cap_valid,
  output logic [31:0]             o_delay_x_value,
  output logic [31:0]             o_delay_y_value,
  output logic [31:0]             o_delay_z_value,
  output logic                    axist_rstn_out,
  output logic [NUM_CH-1:0]       csr_patgen_en,
  output logic [2*NUM_CH-1:0]     csr_patgen_sel,
  output logic [9*NUM_CH-1:0]     csr_patgen_cnt,
  output logic [NUM_CH-1:0]       csr_cntuspatt_en
);

  localparam int unsigned PAGE_W  = ADDR_W - OFF_W;
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PULSE_W = 8;

  logic                    wr_acc;
  logic                    rd_acc;
  logic [PAGE_W-1:0]       page;
  logic [OFF_W-1:0]        off;
  logic                    glb_hit;
  logic                    ch_hit;
  logic [CH_W-1:0]         ch_idx;
  logic                    srst_wr;
  logic [PULSE_W-1:0]      pulse_cnt;
  csr_wr_t                 wr;
  logic [DATA_W-1:0]       ch_rd [NUM_CH];
  logic [DATA_W-1:0]       glb_rd_c;
  logic                    s1_vld;
  logic                    s1_glb;
  logic                    s1_ch_hit;
  logic [CH_W-1:0]         s1_ch;
  logic [OFF_W-1:0]        s1_off;
  logic                    unused_c;

  // A write takes priority over a simultaneous read
  assign wr_acc   = avmm_write && !avmm_waitrequest;
  assign rd_acc   = avmm_read && !avmm_write && !avmm_waitrequest;
  assign page     = avmm_address[ADDR_W-1:OFF_W];
  assign off      = {avmm_address[OFF_W-1:2], 2'b00};
  assign glb_hit  = (page == '0);
  assign ch_hit   = (page != '0) && (page <= PAGE_W'(NUM_CH));
  assign ch_idx   = CH_W'(page - PAGE_W'(1));
  assign wr       = '{off: off, data: avmm_writedata, be: avmm_byteenable};
  assign srst_wr  = wr_acc && glb_hit && (off == REG_CTRL) && avmm_byteenable[0]
                    && avmm_writedata[GCTRL_SRST_BIT];
  assign unused_c = ^avmm_address[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_delay_x_value <= '0;
      o_delay_y_value <= '0;
      o_delay_z_value <= '0;
    end else if (wr_acc && glb_hit) begin
      case (off)
        REG_DLY_X: o_delay_x_value <= be_merge(o_delay_x_value, avmm_writedata, avmm_byteenable);
        REG_DLY_Y: o_delay_y_value <= be_merge(o_delay_y_value, avmm_writedata, avmm_byteenable);
        REG_DLY_Z: o_delay_z_value <= be_merge(o_delay_z_value, avmm_writedata, avmm_byteenable);
        default: ;
      endcase
    end
  end

  // Datapath reset pulse; a trigger reloads the counter even mid-pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_cnt      <= PULSE_W'(RST_PULSE);
      axist_rstn_out <= 1'b0;
    end else if (srst_wr) begin
      pulse_cnt      <= PULSE_W'(RST_PULSE);
      axist_rstn_out <= 1'b0;
    end else begin
      if (pulse_cnt != '0) pulse_cnt <= pulse_cnt - PULSE_W'(1);
      axist_rstn_out <= (pulse_cnt <= PULSE_W'(1));
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    axi_st_csr_chan #(.CAP_W(CAP_W)) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en        (wr_acc && ch_hit && (ch_idx == CH_W'(c))),
      .wr           (wr),
      .rd_off       (s1_off),
      .rd_data_c    (ch_rd[c]),
      .chkr_pass    (chkr_pass[2*c +: 2]),
      .align_error  (align_error[c]),
      .cap_data     (cap_data[c*CAP_W +: CAP_W]),
      .cap_valid    (cap_valid[c]),
      .patgen_en    (csr_patgen_en[c]),
      .patgen_sel   (csr_patgen_sel[2*c +: 2]),
      .patgen_cnt   (csr_patgen_cnt[9*c +: 9]),
      .cntuspatt_en (csr_cntuspatt_en[c])
    );
  end

  always_comb begin
    glb_rd_c = '0;
    case (s1_off)
      REG_ID:    glb_rd_c = {ID_TAG, 8'(NUM_CH), 8'(CAP_W / DATA_W), ID_VER};
      REG_LINK:  glb_rd_c = {28'b0, link_online};
      REG_DLY_X: glb_rd_c = o_delay_x_value;
      REG_DLY_Y: glb_rd_c = o_delay_y_value;
      REG_DLY_Z: glb_rd_c = o_delay_z_value;
      default:   glb_rd_c = '0;
    endcase
  end

  // Two-stage read: decode, then mux; stall keeps one read in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld             <= 1'b0;
      s1_glb             <= 1'b0;
      s1_ch_hit          <= 1'b0;
      s1_ch              <= '0;
      s1_off             <= '0;
      avmm_waitrequest   <= 1'b0;
      avmm_readdatavalid <= 1'b0;
      avmm_readdata      <= '0;
    end else begin
      s1_vld             <= rd_acc;
      avmm_waitrequest   <= rd_acc || s1_vld;
      avmm_readdatavalid <= s1_vld;
      if (rd_acc) begin
        s1_glb    <= glb_hit;
        s1_ch_hit <= ch_hit;
        s1_ch     <= ch_idx;
        s1_off    <= off;
      end
      if (s1_vld) avmm_readdata <= s1_glb ? glb_rd_c : (s1_ch_hit ? ch_rd[s1_ch] : '0);
    end
  end

endmodule
